// File: rtl/multicycle_ctrl_v2.sv
// Multicycle RISC-V style control unit.
// Moore FSM sequencing fetch/decode/execute for R-type, OP-IMM, load, store,
// branch and JAL. Memory waits are bounded; an illegal opcode or a wait
// timeout parks the FSM in TRAP until reset. Also counts retired instructions.
module multicycle_ctrl_v2 #(
  parameter int CNT_W       = 32,
  parameter bit EN_ITYPE    = 1'b1,
  parameter bit EN_JAL      = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       PCSource,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  typedef enum logic [3:0] {
    ST_IF   = 4'd0,
    ST_ID   = 4'd1,
    ST_MA   = 4'd2,
    ST_MEMR = 4'd3,
    ST_MRCS = 4'd4,
    ST_MEMW = 4'd5,
    ST_EX   = 4'd6,
    ST_RT   = 4'd7,
    ST_BC   = 4'd8,
    ST_EXI  = 4'd9,
    ST_JMP  = 4'd10,
    ST_TRAP = 4'd11
  } state_t;

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause_nxt;
  logic              timeout;
  logic              waiting;
  logic              retire;

  assign state   = cur;
  // The three states that wait on memory share one bounded wait counter.
  assign waiting = (cur == ST_IF) || (cur == ST_MEMR) || (cur == ST_MEMW);
  assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_MAX);

  // Next-state and trap-cause selection.
  always_comb begin
    nxt       = cur;
    cause_nxt = 2'b00;
    case (cur)
      ST_IF: begin
        if (mem_ready)    nxt = ST_ID;
        else if (timeout) begin nxt = ST_TRAP; cause_nxt = CAUSE_TMO; end
      end
      ST_ID: begin
        case (opcode)
          OP_RTYPE:          nxt = ST_EX;
          OP_LOAD, OP_STORE: nxt = ST_MA;
          OP_BRANCH:         nxt = ST_BC;
          OP_IMM: begin
            if (EN_ITYPE) nxt = ST_EXI;
            else begin nxt = ST_TRAP; cause_nxt = CAUSE_ILL; end
          end
          OP_JAL: begin
            if (EN_JAL) nxt = ST_JMP;
            else begin nxt = ST_TRAP; cause_nxt = CAUSE_ILL; end
          end
          default: begin nxt = ST_TRAP; cause_nxt = CAUSE_ILL; end
        endcase
      end
      // IR is stable after fetch, so the opcode still tells load from store.
      ST_MA: nxt = (opcode == OP_STORE) ? ST_MEMW : ST_MEMR;
      ST_MEMR: begin
        if (mem_ready)    nxt = ST_MRCS;
        else if (timeout) begin nxt = ST_TRAP; cause_nxt = CAUSE_TMO; end
      end
      ST_MEMW: begin
        if (mem_ready)    nxt = ST_IF;
        else if (timeout) begin nxt = ST_TRAP; cause_nxt = CAUSE_TMO; end
      end
      ST_MRCS: nxt = ST_IF;
      ST_EX:   nxt = ST_RT;
      ST_EXI:  nxt = ST_RT;
      ST_RT:   nxt = ST_IF;
      ST_BC:   nxt = ST_IF;
      ST_JMP:  nxt = ST_IF;
      ST_TRAP: nxt = ST_TRAP;
      // Unused encodings fall back to fetch.
      default: nxt = ST_IF;
    endcase
  end

  // An instruction retires on the edge leaving its last state.
  always_comb begin
    retire = 1'b0;
    case (cur)
      ST_MRCS, ST_RT, ST_BC, ST_JMP: retire = 1'b1;
      ST_MEMW:                       retire = mem_ready;
      default:                       retire = 1'b0;
    endcase
  end

  // State, wait counter, retire counter and sticky trap registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= ST_IF;
      wait_cnt   <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      cur <= nxt;
      // Any state change clears the counter, so each waiting state starts at 0.
      if (nxt != cur)                wait_cnt <= '0;
      else if (waiting && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire) instret <= instret + CNT_W'(1);
      if (nxt == ST_TRAP && cur != ST_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= cause_nxt;
      end
    end
  end

  // Datapath controls decoded from the current state (and mem_ready in IF).
  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 2'b00;
    MemtoReg    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    case (cur)
      ST_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC+4 and IR load only when the fetch actually completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_ID: begin
        ALUSrcB = 2'b10;
        ALUOp   = 2'b00;
      end
      ST_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ST_MEMR: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      ST_MEMW: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      ST_MRCS: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      ST_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ST_EXI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      ST_RT: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b00;
      end
      ST_BC: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      // JAL writes the PC as link value while redirecting to the target.
      ST_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: a vector table walking every instruction
// class, then directed sequences for trap hold, async reset, wait timeouts,
// counter wrap and parameter-disabled opcodes.
module tb_multicycle_ctrl_v2;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] OI  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA,
  //  PCSource,MemtoReg,ALUOp,ALUSrcB}
  localparam logic [15:0] C_IF0  = 16'h1001;
  localparam logic [15:0] C_IF1  = 16'h5401;
  localparam logic [15:0] C_ID   = 16'h0002;
  localparam logic [15:0] C_MA   = 16'h0102;
  localparam logic [15:0] C_MEMR = 16'h3000;
  localparam logic [15:0] C_MEMW = 16'h2800;
  localparam logic [15:0] C_MRCS = 16'h0210;
  localparam logic [15:0] C_EX   = 16'h0108;
  localparam logic [15:0] C_EXI  = 16'h010E;
  localparam logic [15:0] C_RT   = 16'h0200;
  localparam logic [15:0] C_BC   = 16'h8144;
  localparam logic [15:0] C_JMP  = 16'h42A0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic        reset_n, mem_ready;
  logic [6:0]  opcode;
  logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  PCSource, MemtoReg, ALUOp, ALUSrcB, trap_cause;
  logic [31:0] instret;
  logic        trap;
  logic [3:0]  state;
  logic [15:0] ctl;

  multicycle_ctrl_v2 dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCSource(PCSource), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .instret(instret), .trap(trap), .trap_cause(trap_cause), .state(state)
  );
  assign ctl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                PCSource, MemtoReg, ALUOp, ALUSrcB};

  // Narrow counter, OP-IMM and JAL disabled
  logic        reset_b_n, mem_ready_b;
  logic [6:0]  opcode_b;
  logic        pwc_b, pw_b, iord_b, mr_b, mw_b, irw_b, rw_b, asa_b;
  logic [1:0]  pcs_b, m2r_b, aop_b, asb_b, cause_b;
  logic [3:0]  instret_b;
  logic        trap_b;
  logic [3:0]  state_b;
  logic [15:0] ctl_b;

  multicycle_ctrl_v2 #(.CNT_W(4), .EN_ITYPE(1'b0), .EN_JAL(1'b0), .MEM_TIMEOUT(15)) dut_b (
    .clk(clk), .reset_n(reset_b_n), .opcode(opcode_b), .mem_ready(mem_ready_b),
    .PCWriteCond(pwc_b), .PCWrite(pw_b), .IorD(iord_b), .MemRead(mr_b),
    .MemWrite(mw_b), .IRWrite(irw_b), .RegWrite(rw_b), .ALUSrcA(asa_b),
    .PCSource(pcs_b), .MemtoReg(m2r_b), .ALUOp(aop_b), .ALUSrcB(asb_b),
    .instret(instret_b), .trap(trap_b), .trap_cause(cause_b), .state(state_b)
  );
  assign ctl_b = {pwc_b, pw_b, iord_b, mr_b, mw_b, irw_b, rw_b, asa_b,
                  pcs_b, m2r_b, aop_b, asb_b};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        tr;
    logic [1:0]  ca;
    logic [7:0]  ir;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] op, input logic rdy, input logic [3:0] st,
                              input logic [15:0] c, input logic tr, input logic [1:0] ca,
                              input logic [7:0] ir);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.tr = tr; v.ca = ca; v.ir = ir;
    return v;
  endfunction

  vec_t tv[31];

  initial begin
    int n, ok;
    bit done, pw_seen;

    tv[0]  = mk(R,   1, 0,  C_IF1,  0, 0, 0);
    tv[1]  = mk(R,   1, 1,  C_ID,   0, 0, 0);
    tv[2]  = mk(R,   1, 6,  C_EX,   0, 0, 0);
    tv[3]  = mk(R,   1, 7,  C_RT,   0, 0, 0);
    tv[4]  = mk(LD,  1, 0,  C_IF1,  0, 0, 1);
    tv[5]  = mk(LD,  1, 1,  C_ID,   0, 0, 1);
    tv[6]  = mk(LD,  1, 2,  C_MA,   0, 0, 1);
    tv[7]  = mk(LD,  0, 3,  C_MEMR, 0, 0, 1);
    tv[8]  = mk(LD,  0, 3,  C_MEMR, 0, 0, 1);
    tv[9]  = mk(LD,  0, 3,  C_MEMR, 0, 0, 1);
    tv[10] = mk(LD,  1, 3,  C_MEMR, 0, 0, 1);
    tv[11] = mk(LD,  1, 4,  C_MRCS, 0, 0, 1);
    tv[12] = mk(ST,  1, 0,  C_IF1,  0, 0, 2);
    tv[13] = mk(ST,  1, 1,  C_ID,   0, 0, 2);
    tv[14] = mk(ST,  1, 2,  C_MA,   0, 0, 2);
    tv[15] = mk(ST,  0, 5,  C_MEMW, 0, 0, 2);
    tv[16] = mk(ST,  1, 5,  C_MEMW, 0, 0, 2);
    tv[17] = mk(BR,  1, 0,  C_IF1,  0, 0, 3);
    tv[18] = mk(BR,  1, 1,  C_ID,   0, 0, 3);
    tv[19] = mk(BR,  1, 8,  C_BC,   0, 0, 3);
    tv[20] = mk(OI,  1, 0,  C_IF1,  0, 0, 4);
    tv[21] = mk(OI,  1, 1,  C_ID,   0, 0, 4);
    tv[22] = mk(OI,  1, 9,  C_EXI,  0, 0, 4);
    tv[23] = mk(OI,  1, 7,  C_RT,   0, 0, 4);
    tv[24] = mk(JL,  1, 0,  C_IF1,  0, 0, 5);
    tv[25] = mk(JL,  1, 1,  C_ID,   0, 0, 5);
    tv[26] = mk(JL,  1, 10, C_JMP,  0, 0, 5);
    tv[27] = mk(BAD, 1, 0,  C_IF1,  0, 0, 6);
    tv[28] = mk(BAD, 1, 1,  C_ID,   0, 0, 6);
    tv[29] = mk(BAD, 1, 11, 16'h0,  1, 1, 6);
    tv[30] = mk(BAD, 0, 11, 16'h0,  1, 1, 6);

    reset_n = 1'b1; mem_ready = 1'b0; opcode = R;
    reset_b_n = 1'b1; mem_ready_b = 1'b1; opcode_b = R;
    #1 reset_n = 1'b0; reset_b_n = 1'b0;
    #2;
    chk("reset_state", {state, trap, trap_cause, instret}, {4'd0, 1'b0, 2'b00, 32'd0});
    chk("reset_if_outputs", ctl, C_IF0);

    // ---- table walk through every instruction class ----
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      opcode = tv[i].op; mem_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {state, ctl, trap, trap_cause, instret[7:0]},
          {tv[i].st, tv[i].ctl, tv[i].tr, tv[i].ca, tv[i].ir});
      step();
    end

    // ---- TRAP holds for 20 cycles ----
    ok = 0;
    mem_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state == 4'd11 && trap && trap_cause == 2'b01 && ctl == 16'h0 && instret == 32'd6) ok++;
    end
    chk("trap_hold_cycles", ok, 20);

    // ---- async reset out of TRAP, between clock edges ----
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_from_trap", {state, trap, trap_cause, instret}, {4'd0, 1'b0, 2'b00, 32'd0});
    mem_ready = 1'b0;
    #0;
    chk("if_outputs_in_reset", ctl, C_IF0);

    // ---- fetch timeout: 16 cycles in IF then TRAP cause 10 ----
    @(posedge clk); #1;
    reset_n = 1'b1;
    n = 0; done = 1'b0; pw_seen = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (state == 4'd0) n++;
      if (PCWrite) pw_seen = 1'b1;
      if (state == 4'd11) done = 1'b1;
    end
    chk("if_timeout_cycles", n, 16);
    chk("if_timeout_trap", {done, trap, trap_cause}, {1'b1, 1'b1, 2'b10});
    chk("if_timeout_no_pcwrite", pw_seen, 1'b0);

    // ---- load: ready on the 16th MEM_R cycle still completes ----
    reset_n = 1'b0;
    #1 mem_ready = 1'b1; opcode = LD;
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(); step(); step();       // IF -> ID -> MA -> MEM_R
    mem_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (state == 4'd3 && IorD && MemRead) n++;
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    if (state == 4'd3) n++;
    chk("mem_r_wait_cycles", n, 16);
    step();
    @(negedge clk);
    chk("mem_r_boundary_completes", {state, trap, ctl}, {4'd4, 1'b0, C_MRCS});
    step();
    @(negedge clk);
    chk("load_retired", {state, instret}, {4'd0, 32'd1});

    // ---- store: MEM_W timeout traps without retiring ----
    opcode = ST;
    step(); step(); step();       // IF -> ID -> MA -> MEM_W
    mem_ready = 1'b0;
    n = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (state == 4'd5) n++;
      if (state == 4'd11) done = 1'b1;
    end
    chk("mem_w_timeout_cycles", n, 16);
    chk("mem_w_timeout_trap", {done, trap, trap_cause, instret}, {1'b1, 1'b1, 2'b10, 32'd1});

    // ---- narrow build: 17 R-types wrap the counter ----
    @(posedge clk); #1;
    reset_b_n = 1'b1;
    repeat (60) step();
    chk("b_instret_15", instret_b, 4'd15);
    repeat (4) step();
    chk("b_instret_wrap", instret_b, 4'd0);
    repeat (4) step();
    chk("b_instret_end", {state_b, instret_b}, {4'd0, 4'd1});

    // JAL disabled -> illegal
    opcode_b = JL;
    step(); step();
    chk("b_jal_illegal", {state_b, trap_b, cause_b, ctl_b, instret_b},
        {4'd11, 1'b1, 2'b01, 16'h0, 4'd1});

    // OP-IMM disabled -> illegal
    reset_b_n = 1'b0;
    #1;
    chk("b_reset_async", {state_b, trap_b, cause_b, instret_b}, {4'd0, 1'b0, 2'b00, 4'd0});
    opcode_b = OI;
    @(posedge clk); #1;
    reset_b_n = 1'b1;
    step(); step();
    chk("b_itype_illegal", {state_b, trap_b, cause_b}, {4'd11, 1'b1, 2'b01});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_v2.md
MULTICYCLE_CTRL_V2 -- requirements
Module: multicycle_ctrl_v2

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter EN_ITYPE, default 1: enables the OP-IMM path (opcode 0010011); when 0 that opcode is illegal.
REQ-003 Parameter EN_JAL, default 1: enables the JAL path (opcode 1101111); when 0 that opcode is illegal.
REQ-004 Parameter MEM_TIMEOUT, default 15: maximum number of wait cycles per memory access before a bus-error trap.
REQ-005 clk  in  1  single clock; all state changes occur on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 opcode  in  7  instruction opcode from the instruction register.
REQ-008 mem_ready  in  1  memory completes the current access this cycle.
REQ-009 PCWriteCond, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1 each  datapath controls.
REQ-010 PCSource, MemtoReg, ALUOp, ALUSrcB  out  2 each  datapath selects.
REQ-011 instret  out  CNT_W  count of retired instructions.
REQ-012 trap  out  1  sticky error flag.
REQ-013 trap_cause  out  2  trap reason: 01 = illegal opcode, 10 = memory timeout.
REQ-014 state  out  4  current state encoding, for debug.

Function
REQ-015 The block SHALL be a Moore FSM; all control outputs SHALL be decoded from the current state and mem_ready only, and SHALL default to 0 in every state.
REQ-016 States and encodings SHALL be: IF=0, ID=1, MA=2, MEM_R=3, MRCS=4, MEM_W=5, EX=6, RT=7, BC=8, EXI=9, JMP=10, TRAP=11.
REQ-017 IF: MemRead=1, ALUSrcB=01. IRWrite and PCWrite SHALL be 1 only in a cycle where mem_ready=1. Next state: ID on mem_ready, otherwise stay in IF.
REQ-018 ID: ALUSrcB=10, ALUOp=00. Next state by opcode:
  - 0110011 -> EX
  - 0000011 and 0100011 -> MA
  - 1100011 -> BC
  - 0010011 -> EXI when EN_ITYPE=1
  - 1101111 -> JMP when EN_JAL=1
  - any other opcode -> TRAP with trap_cause=01
REQ-019 MA: ALUSrcA=1, ALUSrcB=10. Next state: MEM_R for a load, MEM_W for a store.
REQ-020 MEM_R: IorD=1, MemRead=1. Stay in MEM_R until mem_ready, then go to MRCS.
REQ-021 MEM_W: IorD=1, MemWrite=1. Stay in MEM_W until mem_ready, then go to IF.
REQ-022 MRCS: RegWrite=1, MemtoReg=01; next state IF.
REQ-023 EX: ALUSrcA=1, ALUOp=10; next state RT.
REQ-024 EXI: ALUSrcA=1, ALUSrcB=10, ALUOp=11; next state RT.
REQ-025 RT: RegWrite=1, MemtoReg=00; next state IF.
REQ-026 BC: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01; next state IF.
REQ-027 JMP: PCWrite=1, PCSource=10, RegWrite=1, MemtoReg=10 (write PC as the link value); next state IF.
REQ-028 A wait counter SHALL clear on entry to IF, MEM_R or MEM_W and SHALL increment each cycle spent waiting there with mem_ready=0.
REQ-029 If the wait counter reaches MEM_TIMEOUT with mem_ready still 0, the next state SHALL be TRAP with trap_cause=10. If mem_ready=1 in that same cycle, the access completes normally and no trap occurs.
REQ-030 TRAP SHALL assert trap=1 with all datapath controls 0, and SHALL be left only by reset.
REQ-031 instret SHALL increment by 1 on the edge that leaves MRCS, RT, BC or JMP, and on the edge that leaves MEM_W with mem_ready=1.
REQ-032 instret SHALL wrap from all-ones to 0 and SHALL NOT increment in TRAP.

Reset
REQ-033 When reset_n=0, the following SHALL apply immediately and independently of clk:
  - state=IF
  - instret=0, trap=0, trap_cause=00
  - wait counter=0
REQ-034 Reset asserted in any state, including mid-access or TRAP, SHALL abort the operation; the first fetch SHALL begin on the first rising edge after reset_n returns to 1.
REQ-035 Because outputs follow the state, IF outputs (MemRead=1, ALUSrcB=01) SHALL be visible during reset.

Verification
REQ-036 R-type 0110011 with mem_ready tied to 1 -> states IF,ID,EX,RT,IF; RegWrite=1 only in RT; instret 0->1.
REQ-037 Load 0000011 with mem_ready low for 3 cycles in MEM_R -> MEM_R held for 4 cycles with IorD=1 and MemRead=1, then MRCS with MemtoReg=01; instret=1.
REQ-038 Opcode 1111111 in ID -> TRAP, trap=1, trap_cause=01, held for 20 cycles; reset_n pulsed low -> state=0, trap=0 without a clock edge.
REQ-039 mem_ready held at 0 in IF with MEM_TIMEOUT=15 -> TRAP after 16 cycles in IF, trap_cause=10, PCWrite never asserted.
REQ-040 EN_JAL=0 build: opcode 1101111 -> TRAP with trap_cause=01. EN_JAL=1 build: same opcode -> JMP with PCSource=10 and RegWrite=1.
REQ-041 CNT_W=4 build: 17 back-to-back R-type instructions -> instret wraps 15->0 and ends at 1.
